axi4_frame_writer: RTL
======================

// Module: axi4_frame_writer
// PURPOSE
//  Upstream of the DDR frame reader: accepts 16-bit RGB565 pixels at 100 MHz, packs 4 per 64-bit word, buffers them and
//  writes 64-beat INCR bursts to DDR over an AXI4 write master. Double-buffered: writes the buffer the reader is not
//  reading, toggles buf_select after the last burst of a frame is acknowledged.
// PARAMETERS
//  AXI_ADDR_WIDTH    32            AXI address width
//  AXI_DATA_WIDTH    64            AXI data width (4 pixels/word)
//  BURSTS_PER_FRAME  300           64-beat bursts per frame (320x240 / 256)
//  FIFO_DEPTH        512           packed-word FIFO depth, power of 2, >=128
//  BASE_A / BASE_B   32'h0100_0000 / 32'h0110_0000   frame buffer bases
// PORTS
//  clk_100Mhz  in   1    system / AXI clock
//  rst         in   1    synchronous, active-high reset
//  pix_data    in   16   pixel; pix_valid/pix_ready handshake; pix_sof in 1: first pixel of frame
//  pix_valid   in   1  | pix_ready out 1 | pix_sof in 1
//  AWADDR out 32, AWVALID out 1, AWREADY in 1, AWLEN out 8 (=63), AWSIZE out 3 (=3'b011), AWBURST out 2 (=INCR),
//  AWCACHE out 4 (=4'b1111)
//  WDATA out 64, WSTRB out 8 (=8'hFF), WVALID out 1, WREADY in 1, WLAST out 1
//  BVALID in 1, BRESP in 2, BREADY out 1
//  buf_select  out  1    to reader; reader reads BASE_B when 1, writer writes BASE_A when 1
//  frame_done  out  1    one-cycle pulse on buf_select toggle
//  resp_err    out  1    sticky: any BRESP != OKAY;  frame_err out 1: sticky, sof misaligned
//  state       out  2    FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, packer lane 0, FIFO empty, offset 0, burst_cnt 0. Write base = buf_select?BASE_A:BASE_B.
//  Packer: pixel k of word at bits [63-16k -: 16] (MSB first, matches reader's 64->16 FIFO). Word pushed on 4th pixel.
//   pix_sof on accepted pixel: lane forced to 0 (partial word discarded), pixel becomes lane 0, word tagged sof.
//   pix_ready = (fifo_count < FIFO_DEPTH); push and pop same cycle allowed; no overflow possible.
//  FIFO: sync FWFT, 65 bits (sof tag + data).
//  FSM: IDLE -> ADDR_SEND when fifo_count >= 64. On entry check head tag: if sof && burst_cnt!=0, set burst_cnt=0,
//   offset=0, frame_err=1, no toggle. Head sof tag with burst_cnt==0 is normal.
//   ADDR_SEND: AWADDR = base + offset latched on entry, AWVALID=1 held with stable AWADDR until AWREADY; -> DATA_WRITE.
//   DATA_WRITE: W starts only after AW handshake; WVALID=1, WDATA=FIFO head, pop on WVALID&&WREADY; beat counter
//    0..63, WLAST=1 on beat 63; on last handshake WVALID=0 -> RESP_WAIT. Sof tag on a non-first beat: frame_err=1,
//    data written unchanged.
//   RESP_WAIT: BREADY=1; on BVALID: BREADY=0, BRESP!=0 sets resp_err (frame continues), offset += 512,
//    burst_cnt++; if burst_cnt reaches BURSTS_PER_FRAME: burst_cnt=0, offset=0, buf_select toggles, frame_done pulse.
//    -> IDLE.
//  Latency: AWVALID 1 cycle after FIFO reaches 64 words; no bubble between W beats when WREADY=1.
//  Reset mid-burst: AXI outputs drop next cycle; slave-side cleanup is the interconnect's job (system reset).
// CONFIGURATION
//  WR_STATS_EN defined: adds ports stat_frames out 16 (completed frames, wraps) and stat_wstall out 32 (cycles
//   WVALID&&!WREADY, cleared on frame_done). Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package axi_fb_pkg: burst len 64, AWSIZE/AWBURST/AWCACHE constants, BASE_A/BASE_B, bytes/burst 512, state enum
//   IDLE=0 ADDR_SEND=1 DATA_WRITE=2 RESP_WAIT=3, BRESP OKAY.
//  Sub-module: fb_sync_fifo (parametric width/depth, FWFT, count output). Packer and FSM in top.
// TESTING
//  1 Reset: all outputs 0, pix_ready=1, AWVALID=0 for 20 cycles with no input.
//  2 76800 ramp pixels, sof on first, AW/W/B always ready -> 300 bursts at 0x0110_0000+n*512, WLAST every 64th beat,
//    buf_select 0->1, single frame_done; DDR model data equals packed ramp.
//  3 Second frame -> addresses 0x0100_0000+n*512, buf_select 1->0.
//  4 AWREADY delayed 5 cycles, WREADY random 50%, pixels stalled -> AWADDR/AWVALID stable until handshake, no data loss,
//    pix_ready=0 when FIFO holds 512 words.
//  5 BRESP=SLVERR on burst 10 -> resp_err=1 stays, frame completes and toggles normally.
//  6 sof after 100 bursts -> next AW at base+0, buf_select unchanged, frame_err=1; full frame then toggles.

Source files
------------

// File: rtl/axi_fb_pkg.sv
// Shared constants and the state encoding for the AXI4 frame-buffer writer.
package axi_fb_pkg;

   localparam int          FB_PIXEL_WIDTH      = 16;
   localparam int          FB_BURST_LEN        = 64;
   localparam int          FB_BYTES_PER_BURST  = 512;
   localparam logic [7:0]  FB_AWLEN            = 8'(FB_BURST_LEN - 1);
   localparam logic [2:0]  FB_AWSIZE           = 3'b011;
   localparam logic [1:0]  FB_AWBURST          = 2'b01;
   localparam logic [3:0]  FB_AWCACHE          = 4'b1111;
   localparam logic [31:0] FB_BASE_A           = 32'h0100_0000;
   localparam logic [31:0] FB_BASE_B           = 32'h0110_0000;
   localparam logic [1:0]  FB_BRESP_OKAY       = 2'b00;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ADDR_SEND  = 2'd1,
      DATA_WRITE = 2'd2,
      RESP_WAIT  = 2'd3
   } wr_state_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
module fb_sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 512
) (
   input  logic                     clk_100Mhz,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && (count != CW'(DEPTH));
   assign do_pop   = pop && (count != '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk_100Mhz) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi4_frame_writer.sv
// Packs RGB565 pixels into 64-bit words and writes double-buffered frames as 64-beat AXI4 INCR bursts.
// Optional macro WR_STATS_EN adds frame and write-stall statistics counters.
//
//  state      | meaning
//  IDLE       | waiting for a full burst of words in the FIFO
//  ADDR_SEND  | AWVALID held with latched AWADDR until AWREADY
//  DATA_WRITE | streaming 64 beats from the FIFO head
//  RESP_WAIT  | BREADY high, waiting for the write response
module axi4_frame_writer
   import axi_fb_pkg::*;
#(
   parameter int                        AXI_ADDR_WIDTH   = 32,
   parameter int                        AXI_DATA_WIDTH   = 64,
   parameter int                        BURSTS_PER_FRAME = 300,
   parameter int                        FIFO_DEPTH       = 512,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_A           = AXI_ADDR_WIDTH'(FB_BASE_A),
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_B           = AXI_ADDR_WIDTH'(FB_BASE_B)
) (
   input  logic                        clk_100Mhz,
   input  logic                        rst,
   input  logic [15:0]                 pix_data,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   input  logic                        pix_sof,
   output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
   output logic                        AWVALID,
   input  logic                        AWREADY,
   output logic [7:0]                  AWLEN,
   output logic [2:0]                  AWSIZE,
   output logic [1:0]                  AWBURST,
   output logic [3:0]                  AWCACHE,
   output logic [AXI_DATA_WIDTH-1:0]   WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
   output logic                        WVALID,
   input  logic                        WREADY,
   output logic                        WLAST,
   input  logic                        BVALID,
   input  logic [1:0]                  BRESP,
   output logic                        BREADY,
   output logic                        buf_select,
   output logic                        frame_done,
   output logic                        resp_err,
   output logic                        frame_err,
   output logic [1:0]                  state
`ifdef WR_STATS_EN
   ,
   output logic [15:0]                 stat_frames,
   output logic [31:0]                 stat_wstall
`endif
);

   localparam int LANES  = AXI_DATA_WIDTH / FB_PIXEL_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BC_W   = $clog2(BURSTS_PER_FRAME + 1);
   localparam int BEAT_W = $clog2(FB_BURST_LEN);
   localparam int FIFO_W = AXI_DATA_WIDTH + 1;

   // packer
   logic [LANE_W-1:0]         lane_q;
   logic [LANE_W-1:0]         lane_eff;
   logic [AXI_DATA_WIDTH-1:0] word_acc_q;
   logic                      sof_tag_q;
   logic                      pix_acc;
   logic                      word_done;
   logic [FIFO_W-1:0]         push_word;

   logic [FIFO_W-1:0]         head;
   logic [CNT_W-1:0]          fifo_count;
   logic                      fifo_pop;
   logic                      head_sof;

   assign pix_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign pix_acc   = pix_valid && pix_ready;
   assign lane_eff  = pix_sof ? '0 : lane_q;
   assign word_done = pix_acc && (lane_eff == LANE_W'(LANES - 1));
   assign push_word = {sof_tag_q, word_acc_q[AXI_DATA_WIDTH-1:FB_PIXEL_WIDTH], pix_data};

   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         lane_q     <= '0;
         word_acc_q <= '0;
         sof_tag_q  <= 1'b0;
      end else if (pix_acc) begin
         word_acc_q[AXI_DATA_WIDTH-1-FB_PIXEL_WIDTH*int'(lane_eff) -: FB_PIXEL_WIDTH] <= pix_data;
         if (word_done) begin
            lane_q    <= '0;
            sof_tag_q <= 1'b0;
         end else begin
            lane_q    <= lane_eff + 1'b1;
            sof_tag_q <= pix_sof | sof_tag_q;
         end
      end
   end

   fb_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_100Mhz (clk_100Mhz),
      .rst        (rst),
      .push       (word_done),
      .push_data  (push_word),
      .pop        (fifo_pop),
      .pop_data   (head),
      .count      (fifo_count)
   );

   assign head_sof = head[AXI_DATA_WIDTH];

   // write FSM
   wr_state_t                 state_q;
   wr_state_t                 state_d;
   logic [BEAT_W-1:0]         beat_q;
   logic [BC_W-1:0]           burst_cnt_q;
   logic [AXI_ADDR_WIDTH-1:0] offset_q;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_ADDR_WIDTH-1:0] base;
   logic                      buf_sel_q;
   logic                      frame_done_q;
   logic                      resp_err_q;
   logic                      frame_err_q;
   logic                      burst_ready;
   logic                      last_beat;
   logic                      misaligned;
   logic                      last_burst;
   logic                      awvalid_c;
   logic                      wvalid_c;
   logic                      bready_c;

   assign base        = buf_sel_q ? BASE_A : BASE_B;
   assign burst_ready = (fifo_count >= CNT_W'(FB_BURST_LEN));
   assign last_beat   = (beat_q == BEAT_W'(FB_BURST_LEN - 1));
   assign misaligned  = head_sof && (burst_cnt_q != '0);
   assign last_burst  = (burst_cnt_q == BC_W'(BURSTS_PER_FRAME - 1));

   always_ff @(posedge clk_100Mhz) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      awvalid_c = 1'b0;
      wvalid_c  = 1'b0;
      bready_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (burst_ready) state_d = ADDR_SEND;
         end
         ADDR_SEND: begin
            awvalid_c = 1'b1;
            if (AWREADY) state_d = DATA_WRITE;
         end
         DATA_WRITE: begin
            wvalid_c = 1'b1;
            if (WREADY && last_beat) state_d = RESP_WAIT;
         end
         RESP_WAIT: begin
            bready_c = 1'b1;
            if (BVALID) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_pop = wvalid_c && WREADY;

   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         beat_q       <= '0;
         burst_cnt_q  <= '0;
         offset_q     <= '0;
         awaddr_q     <= '0;
         buf_sel_q    <= 1'b0;
         frame_done_q <= 1'b0;
         resp_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // a new frame arriving mid-frame restarts the buffer from its base
               if (burst_ready) begin
                  if (misaligned) begin
                     burst_cnt_q <= '0;
                     offset_q    <= '0;
                     frame_err_q <= 1'b1;
                     awaddr_q    <= base;
                  end else begin
                     awaddr_q    <= base + offset_q;
                  end
               end
            end
            DATA_WRITE: begin
               if (WREADY) begin
                  beat_q <= beat_q + 1'b1;
                  if (head_sof && (beat_q != '0)) frame_err_q <= 1'b1;
               end
            end
            RESP_WAIT: begin
               if (BVALID) begin
                  if (BRESP != FB_BRESP_OKAY) resp_err_q <= 1'b1;
                  if (last_burst) begin
                     burst_cnt_q  <= '0;
                     offset_q     <= '0;
                     buf_sel_q    <= ~buf_sel_q;
                     frame_done_q <= 1'b1;
                  end else begin
                     burst_cnt_q  <= burst_cnt_q + 1'b1;
                     offset_q     <= offset_q + AXI_ADDR_WIDTH'(FB_BYTES_PER_BURST);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign AWADDR     = awaddr_q;
   assign AWVALID    = awvalid_c;
   assign AWLEN      = FB_AWLEN;
   assign AWSIZE     = FB_AWSIZE;
   assign AWBURST    = FB_AWBURST;
   assign AWCACHE    = FB_AWCACHE;
   assign WDATA      = wvalid_c ? head[AXI_DATA_WIDTH-1:0] : '0;
   assign WSTRB      = '1;
   assign WVALID     = wvalid_c;
   assign WLAST      = wvalid_c && last_beat;
   assign BREADY     = bready_c;
   assign buf_select = buf_sel_q;
   assign frame_done = frame_done_q;
   assign resp_err   = resp_err_q;
   assign frame_err  = frame_err_q;
   assign state      = state_q;

`ifdef WR_STATS_EN
   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         stat_frames <= '0;
         stat_wstall <= '0;
      end else begin
         if (frame_done_q) stat_frames <= stat_frames + 1'b1;
         if (frame_done_q)              stat_wstall <= '0;
         else if (wvalid_c && !WREADY)  stat_wstall <= stat_wstall + 1'b1;
      end
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule
